// File: rtl/otter_pipe_pkg.sv
// rtl/otter_pipe_pkg.sv - shared state, control bundle and constants for the OTTER hazard sequencer
package otter_pipe_pkg;

  typedef enum logic [1:0] {
    RUN         = 2'b00,
    LOAD_BUBBLE = 2'b01,
    MEM_WAIT    = 2'b10
  } hz_state_t;

  typedef struct packed {
    logic pc_we;
    logic pc_redirect;
    logic if_id_we;
    logic id_ex_we;
    logic ex_mem_we;
    logic mem_wb_we;
    logic if_id_flush;
    logic id_ex_flush;
    logic mem_wb_flush;
  } pipe_ctrl_t;

  // Free-running pipeline: every stage advances, nothing squashed.
  localparam pipe_ctrl_t CTRL_RUN = '{
    pc_we: 1'b1, pc_redirect: 1'b0, if_id_we: 1'b1, id_ex_we: 1'b1,
    ex_mem_we: 1'b1, mem_wb_we: 1'b1,
    if_id_flush: 1'b0, id_ex_flush: 1'b0, mem_wb_flush: 1'b0
  };

  // Held in reset: nothing written, all flush inputs forced to NOP.
  localparam pipe_ctrl_t CTRL_RESET = '{
    pc_we: 1'b0, pc_redirect: 1'b0, if_id_we: 1'b0, id_ex_we: 1'b0,
    ex_mem_we: 1'b0, mem_wb_we: 1'b0,
    if_id_flush: 1'b1, id_ex_flush: 1'b1, mem_wb_flush: 1'b1
  };

endpackage

// File: rtl/hz_wait_timer.sv
// rtl/hz_wait_timer.sv - saturating memory-wait counter with sticky timeout flag
module hz_wait_timer #(
  parameter int MEM_TIMEOUT = 64
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_count_en,
  output logic o_timeout
);

  localparam int W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [W-1:0] LIMIT = W'(MEM_TIMEOUT);

  logic [W-1:0] r_cnt;
  logic [W-1:0] w_cnt_next;
  logic         r_timeout;

  // Saturate at the limit so a very long wait never wraps back to zero.
  always_comb begin
    w_cnt_next = (r_cnt == LIMIT) ? r_cnt : r_cnt + W'(1);
  end

  // Count stalled MEM_WAIT cycles; any cycle without a stalled wait clears the count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else if (i_count_en) begin
      r_cnt <= w_cnt_next;
      if ((MEM_TIMEOUT != 0) && (w_cnt_next == LIMIT)) begin
        r_timeout <= 1'b1;
      end
    end else begin
      r_cnt <= '0;
    end
  end

  assign o_timeout = r_timeout;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - OTTER stall/flush sequencer; PIPE_PERF_CNT_EN builds the perf counters
module pipe_hazard_ctrl
  import otter_pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             STALL_REQ,
  input  logic             BR_TAKEN,
  input  logic             DMEM_BUSY,
  output logic             PC_WE,
  output logic             PC_REDIRECT,
  output logic             IF_ID_WE,
  output logic             ID_EX_WE,
  output logic             EX_MEM_WE,
  output logic             MEM_WB_WE,
  output logic             IF_ID_FLUSH,
  output logic             ID_EX_FLUSH,
  output logic             MEM_WB_FLUSH,
  output logic [1:0]       STATE_O,
  output logic             MEM_TIMEOUT_ERR,
  output logic [CNT_W-1:0] STALL_CNT,
  output logic [CNT_W-1:0] FLUSH_CNT,
  output logic [CNT_W-1:0] WAIT_CNT
);

  hz_state_t  r_state;
  hz_state_t  w_next_state;
  pipe_ctrl_t w_ctrl;
  logic       w_wait_en;

  // State register; reset discards any pending bubble or wait.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Same-cycle decode, priority DMEM_BUSY > BR_TAKEN > STALL_REQ; the encoding 2'b11 falls through as RUN.
  always_comb begin
    w_ctrl       = CTRL_RUN;
    w_next_state = RUN;
    if (RST) begin
      w_ctrl = CTRL_RESET;
    end else if (DMEM_BUSY) begin
      // Freeze the front of the pipe; MEM/WB keeps clocking NOPs so the stalled access is not written back twice.
      w_ctrl.pc_we        = 1'b0;
      w_ctrl.if_id_we     = 1'b0;
      w_ctrl.id_ex_we     = 1'b0;
      w_ctrl.ex_mem_we    = 1'b0;
      w_ctrl.mem_wb_flush = 1'b1;
      w_next_state        = MEM_WAIT;
    end else if (BR_TAKEN) begin
      w_ctrl.pc_redirect = 1'b1;
      w_ctrl.if_id_flush = 1'b1;
      w_ctrl.id_ex_flush = 1'b1;
    end else if (STALL_REQ && (r_state != LOAD_BUBBLE)) begin
      // One bubble only: in LOAD_BUBBLE the load has reached MEM and forwarding covers it.
      w_ctrl.pc_we       = 1'b0;
      w_ctrl.if_id_we    = 1'b0;
      w_ctrl.id_ex_flush = 1'b1;
      w_next_state       = LOAD_BUBBLE;
    end
  end

  assign w_wait_en = (r_state == MEM_WAIT) && DMEM_BUSY;

  hz_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait_timer (
    .i_clk      (CLK),
    .i_rst      (RST),
    .i_count_en (w_wait_en),
    .o_timeout  (MEM_TIMEOUT_ERR)
  );

  assign PC_WE        = w_ctrl.pc_we;
  assign PC_REDIRECT  = w_ctrl.pc_redirect;
  assign IF_ID_WE     = w_ctrl.if_id_we;
  assign ID_EX_WE     = w_ctrl.id_ex_we;
  assign EX_MEM_WE    = w_ctrl.ex_mem_we;
  assign MEM_WB_WE    = w_ctrl.mem_wb_we;
  assign IF_ID_FLUSH  = w_ctrl.if_id_flush;
  assign ID_EX_FLUSH  = w_ctrl.id_ex_flush;
  assign MEM_WB_FLUSH = w_ctrl.mem_wb_flush;
  assign STATE_O      = r_state;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic [CNT_W-1:0] r_wait_cnt;
  logic             w_load_use;

  // An ID/EX flush without a redirect (and outside reset) can only come from a load-use bubble.
  assign w_load_use = w_ctrl.id_ex_flush & ~w_ctrl.pc_redirect & ~RST;

  // Wrapping event counters for bubbles, redirects and busy memory cycles.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_wait_cnt  <= '0;
    end else begin
      if (w_load_use)         r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_ctrl.pc_redirect) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      if (DMEM_BUSY)          r_wait_cnt  <= r_wait_cnt + CNT_W'(1);
    end
  end

  assign STALL_CNT = r_stall_cnt;
  assign FLUSH_CNT = r_flush_cnt;
  assign WAIT_CNT  = r_wait_cnt;
`else
  assign STALL_CNT = '0;
  assign FLUSH_CNT = '0;
  assign WAIT_CNT  = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl (honours PIPE_PERF_CNT_EN)
module tb_pipe_hazard_ctrl;

  localparam int TO = 4;
  localparam int CW = 32;

  // Control vector order: pc_we, pc_redirect, if_id_we, id_ex_we, ex_mem_we, mem_wb_we, if_id_flush, id_ex_flush, mem_wb_flush
  localparam logic [8:0] C_RST   = 9'b000000111;
  localparam logic [8:0] C_RUN   = 9'b101111000;
  localparam logic [8:0] C_STALL = 9'b000111010;
  localparam logic [8:0] C_BR    = 9'b111111110;
  localparam logic [8:0] C_BUSY  = 9'b000001001;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic RST = 1'b1, STALL_REQ = 1'b0, BR_TAKEN = 1'b0, DMEM_BUSY = 1'b0;
  logic PC_WE, PC_REDIRECT, IF_ID_WE, ID_EX_WE, EX_MEM_WE, MEM_WB_WE;
  logic IF_ID_FLUSH, ID_EX_FLUSH, MEM_WB_FLUSH, MEM_TIMEOUT_ERR;
  logic [1:0] STATE_O;
  logic [CW-1:0] STALL_CNT, FLUSH_CNT, WAIT_CNT;
  logic [8:0] w_ctrl;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST), .STALL_REQ(STALL_REQ), .BR_TAKEN(BR_TAKEN), .DMEM_BUSY(DMEM_BUSY),
    .PC_WE(PC_WE), .PC_REDIRECT(PC_REDIRECT), .IF_ID_WE(IF_ID_WE), .ID_EX_WE(ID_EX_WE),
    .EX_MEM_WE(EX_MEM_WE), .MEM_WB_WE(MEM_WB_WE), .IF_ID_FLUSH(IF_ID_FLUSH),
    .ID_EX_FLUSH(ID_EX_FLUSH), .MEM_WB_FLUSH(MEM_WB_FLUSH), .STATE_O(STATE_O),
    .MEM_TIMEOUT_ERR(MEM_TIMEOUT_ERR), .STALL_CNT(STALL_CNT), .FLUSH_CNT(FLUSH_CNT),
    .WAIT_CNT(WAIT_CNT)
  );

  assign w_ctrl = {PC_WE, PC_REDIRECT, IF_ID_WE, ID_EX_WE, EX_MEM_WE, MEM_WB_WE,
                   IF_ID_FLUSH, ID_EX_FLUSH, MEM_WB_FLUSH};

  int checks = 0;
  int errors = 0;

  // Reference model: what the pipeline has experienced so far.
  bit          m_valid = 1'b0;
  bit          m_bubbled;      // previous cycle inserted a load-use bubble
  bit          m_waiting;      // previous cycle was a memory stall
  int          m_busy_run;     // consecutive busy cycles since the last non-busy/reset cycle
  bit          m_err;
  logic [CW-1:0] m_sc, m_fc, m_wc;

  typedef struct {
    bit         rst, stall, br, busy;
    logic [8:0] ctrl;
    logic [1:0] st;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] exp_ctrl(input bit rst, input bit stall, input bit br,
                                          input bit busy, input bit bubbled);
    if (rst)                   return C_RST;
    if (busy)                  return C_BUSY;
    if (br)                    return C_BR;
    if (stall && !bubbled)     return C_STALL;
    return C_RUN;
  endfunction

  function automatic logic [1:0] exp_state();
    if (m_waiting) return 2'b10;
    if (m_bubbled) return 2'b01;
    return 2'b00;
  endfunction

  // Apply one cycle of inputs, check against the model, then advance the model across the coming edge.
  task automatic step(input bit rst, input bit stall, input bit br, input bit busy);
    logic [95:0] cnt_exp;
    bit ins_bubble;
    @(negedge CLK);
    RST = rst; STALL_REQ = stall; BR_TAKEN = br; DMEM_BUSY = busy;
    #1;
    chk("ctrl", {87'b0, w_ctrl}, {87'b0, exp_ctrl(rst, stall, br, busy, m_valid && m_bubbled)});
    if (m_valid) begin
`ifdef PIPE_PERF_CNT_EN
      cnt_exp = {m_sc, m_fc, m_wc};
`else
      cnt_exp = '0;
`endif
      chk("state", {94'b0, STATE_O}, {94'b0, exp_state()});
      chk("timeout_err", {95'b0, MEM_TIMEOUT_ERR}, {95'b0, m_err});
      chk("perf_cnt", {STALL_CNT, FLUSH_CNT, WAIT_CNT}, cnt_exp);
    end
    if (rst) begin
      m_bubbled = 0; m_waiting = 0; m_busy_run = 0; m_err = 0;
      m_sc = '0; m_fc = '0; m_wc = '0;
    end else begin
      ins_bubble = !busy && !br && stall && !m_bubbled;
      if (busy) m_wc = m_wc + 1;
      if (!busy && br) m_fc = m_fc + 1;
      if (ins_bubble) m_sc = m_sc + 1;
      m_busy_run = busy ? m_busy_run + 1 : 0;
      // The first busy cycle is spent entering MEM_WAIT, so the limit is hit one cycle later.
      if (TO != 0 && m_busy_run >= TO + 1) m_err = 1;
      m_bubbled = ins_bubble;
      m_waiting = busy;
    end
    m_valid = 1'b1;
  endtask

  initial begin
    tbl[0]  = '{1, 0, 0, 0, C_RST,   2'b00};
    tbl[1]  = '{0, 0, 0, 0, C_RUN,   2'b00};
    tbl[2]  = '{0, 1, 0, 0, C_STALL, 2'b00};
    tbl[3]  = '{0, 1, 0, 0, C_RUN,   2'b01};
    tbl[4]  = '{0, 0, 0, 0, C_RUN,   2'b00};
    tbl[5]  = '{0, 1, 1, 0, C_BR,    2'b00};
    tbl[6]  = '{0, 0, 0, 0, C_RUN,   2'b00};
    tbl[7]  = '{0, 0, 1, 1, C_BUSY,  2'b00};
    tbl[8]  = '{0, 0, 1, 1, C_BUSY,  2'b10};
    tbl[9]  = '{0, 0, 1, 1, C_BUSY,  2'b10};
    tbl[10] = '{0, 0, 1, 1, C_BUSY,  2'b10};
    tbl[11] = '{0, 0, 1, 1, C_BUSY,  2'b10};
    tbl[12] = '{0, 0, 1, 0, C_BR,    2'b10};
    tbl[13] = '{0, 1, 0, 0, C_STALL, 2'b00};
    tbl[14] = '{0, 0, 0, 1, C_BUSY,  2'b01};
    tbl[15] = '{0, 1, 0, 0, C_STALL, 2'b10};
    tbl[16] = '{0, 1, 0, 0, C_RUN,   2'b01};
    tbl[17] = '{0, 0, 0, 0, C_RUN,   2'b00};

    // Two reset cycles, then the directed table.
    step(1, 0, 0, 0);
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].rst, tbl[i].stall, tbl[i].br, tbl[i].busy);
      chk($sformatf("tbl%0d_ctrl", i), {87'b0, w_ctrl}, {87'b0, tbl[i].ctrl});
      chk($sformatf("tbl%0d_state", i), {94'b0, STATE_O}, {94'b0, tbl[i].st});
    end

    // Timeout: four MEM_WAIT cycles after entry raise the flag; it survives the end of the wait.
    step(1, 0, 0, 0);
    for (int k = 1; k <= 10; k++) begin
      step(0, 0, 0, 1);
      chk($sformatf("to_err_k%0d", k), {95'b0, MEM_TIMEOUT_ERR}, {95'b0, (k >= 6)});
    end
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("to_err_sticky", {95'b0, MEM_TIMEOUT_ERR}, 96'd1);

    // Reset in the middle of a memory wait, then busy still high after release.
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(1, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("rst_mid_state", {94'b0, STATE_O}, 96'd0);
    chk("rst_mid_err", {95'b0, MEM_TIMEOUT_ERR}, 96'd0);
    chk("rst_mid_wait_cnt", {64'b0, WAIT_CNT}, 96'd0);
    step(0, 0, 0, 0);
    chk("rst_mid_reenter", {94'b0, STATE_O}, 96'd2);

    // Randomised traffic with bursty memory stalls and occasional resets.
    begin
      int busy_left = 0;
      bit r_rst, r_busy;
      for (int n = 0; n < 600; n++) begin
        r_rst = ($urandom_range(0, 63) == 0);
        if (busy_left == 0 && $urandom_range(0, 5) == 0) busy_left = $urandom_range(1, 9);
        r_busy = (busy_left > 0);
        if (busy_left > 0) busy_left--;
        step(r_rst, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, r_busy);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
